// File: rtl/adder_tree_accum.sv
// adder_tree_accum: sums ACC_LEN consecutive adder_tree results into one wider word and buffers
// the words in a drop-on-full FIFO. Define ADDER_TREE_ACCUM_DROP_CNT_EN to add the o_drop_cnt port.
module adder_tree_accum #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned ACC_LEN    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned OUT_WIDTH = IN_WIDTH + $clog2(ACC_LEN) + 1,
  localparam int unsigned CNT_WIDTH = $clog2(ACC_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [IN_WIDTH-1:0]  i_sum,
  input  logic                 i_clear,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow
`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
  ,
  output logic [7:0]           o_drop_cnt
`endif
);

  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);
  localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(FIFO_DEPTH);
  localparam bit SINGLE = (ACC_LEN == 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] sum_ext;
  logic [OUT_WIDTH-1:0] acc_next;
  logic                 fresh;
  logic                 last;
  logic                 complete;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 drop;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [OCC_WIDTH-1:0] occ;
  logic [OCC_WIDTH-1:0] occ_next;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

  always_comb begin
    sum_ext  = {{(OUT_WIDTH - IN_WIDTH){1'b0}}, i_sum};
    fresh    = i_clear || (o_count == '0);
    last     = (o_count == LAST_CNT);
    acc_next = fresh ? sum_ext : acc + sum_ext;
    // A clear restarts the window, so it can only complete when the window is one sample long
    complete = i_valid && last && (!i_clear || SINGLE);
    o_valid  = (occ != '0);
    o_data   = o_valid ? mem[rd_ptr] : '0;
    pop      = o_valid && o_ready;
    full     = (occ == FULL_OCC);
    wr_en    = complete && (!full || pop);
    drop     = complete && full && !pop;
    occ_next = occ;
    if (wr_en && !pop) begin
      occ_next = occ + OCC_WIDTH'(1);
    end else if (!wr_en && pop) begin
      occ_next = occ - OCC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      o_count    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_valid) begin
        acc <= acc_next;
        if (complete) begin
          o_count <= '0;
        end else if (fresh) begin
          o_count <= CNT_WIDTH'(1);
        end else begin
          o_count <= o_count + CNT_WIDTH'(1);
        end
      end else if (i_clear) begin
        acc     <= '0;
        o_count <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      occ <= occ_next;
      if (drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= acc_next;
    end
  end

`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_drop_cnt <= '0;
    end else if (drop && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_accum.sv
// Scoreboard bench for adder_tree_accum: window/FIFO reference model built from sample lists
// and a capacity-limited result queue; a negedge monitor checks every presented head.
module tb_adder_tree_accum;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned ACC   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OUT_W = IN_W + $clog2(ACC) + 1;
  localparam int unsigned CNT_W = $clog2(ACC + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic [IN_W-1:0]  i_sum = '0;
  logic             i_clear = 1'b0;
  logic             o_ready = 1'b0;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
  logic [7:0]       o_drop_cnt;
`endif

  adder_tree_accum #(.IN_WIDTH(IN_W), .ACC_LEN(ACC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sum(i_sum), .i_clear(i_clear),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_count(o_count),
    .o_overflow(o_overflow)
`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int win[$];
  int mdl_occ = 0;
  int mdl_ovf = 0;
  int mdl_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whatever the DUT presents must be the oldest accepted result
  always @(negedge clk) begin
    if (rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL o_data_unexpected: got %0d expected no output at %0t", o_data, $time);
      end else begin
        chk("o_data", o_data, exp_q[0]);
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; called just after a rising edge
  task automatic step(input bit v, input int s, input bit c, input bit r);
    int occ0;
    bit pop;
    bit push;
    int res;
    chk("o_valid", o_valid, (mdl_occ > 0));
    chk("o_count", o_count, win.size());
    chk("o_overflow", o_overflow, mdl_ovf);
`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
    chk("o_drop_cnt", o_drop_cnt, mdl_drop);
`endif
    i_valid = v;
    i_sum   = s[IN_W-1:0];
    i_clear = c;
    o_ready = r;
    occ0 = mdl_occ;
    pop  = (occ0 > 0) && r;
    push = 1'b0;
    res  = 0;
    if (c) win.delete();
    if (v) begin
      win.push_back(s & 255);
      if (win.size() == ACC) begin
        foreach (win[k]) res += win[k];
        win.delete();
        push = 1'b1;
      end
    end
    mdl_occ = occ0 - (pop ? 1 : 0);
    if (push) begin
      if (occ0 < DEPTH || pop) begin
        exp_q.push_back(res);
        mdl_occ++;
      end else begin
        mdl_ovf = 1;
        if (mdl_drop < 255) mdl_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mdl_occ > 0 || o_valid) && guard < 50) begin
      step(0, 0, 0, 1);
      guard++;
    end
    step(0, 0, 0, 1);
    if (guard >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", mdl_occ);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_count", o_count, 0);
    chk("rst_o_overflow", o_overflow, 0);
    rst = 1'b1;

    // Basic window of four
    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, 30, 0, 1);
    step(1, 40, 0, 1);
    chk("t2_sum", o_data, 100);
    drain();

    // Clear discards the partial window
    step(1, 5, 0, 1);
    step(1, 7, 0, 1);
    step(0, 0, 1, 1);
    repeat (4) step(1, 1, 0, 1);
    chk("t3_sum", o_data, 4);
    drain();

    // Clear together with a sample starts a fresh window
    step(1, 3, 0, 1);
    step(1, 3, 0, 1);
    step(1, 9, 1, 1);
    repeat (3) step(1, 1, 0, 1);
    chk("t4_sum", o_data, 12);
    drain();

    // Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) begin
      repeat (4) step(1, 10 * k, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);
    chk("t6_head", o_data, 40);
    repeat (3) step(1, 50, 0, 0);
    step(1, 50, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    chk("t6_no_overflow", o_overflow, 0);
    chk("t6_head2", o_data, 80);
    drain();

    // Five windows into a four-entry FIFO with no consumer
    repeat (20) step(1, 255, 0, 0);
    chk("t5_overflow", o_overflow, 1);
`ifdef ADDER_TREE_ACCUM_DROP_CNT_EN
    chk("t5_drop_cnt", o_drop_cnt, 1);
`endif
    for (int k = 0; k < 4; k++) begin
      chk("t5_drain", o_data, 1020);
      step(0, 0, 0, 1);
    end
    chk("t5_empty", o_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 70), int'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 50));
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
